dds_voice_engine: RTL and testbench

DDS_VOICE_ENGINE -- requirements
Module: dds_voice_engine

---
 rtl/dds_voice_engine.sv | 140 ++++++++++++++
 tb/tb_dds_voice_engine.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_voice_engine.sv
// Time-multiplexed DDS voice engine: NUM_VOICES phase accumulators scanned once per sample_tick and summed.
// Latency: mix_valid NUM_VOICES+1 cycles after the tick edge; config writes stall (cfg_ready low) during a scan.
module dds_voice_engine #(
    parameter int NUM_VOICES = 4,
    parameter int TUNE_WIDTH = 16,
    parameter int WAVE_WIDTH = 12,
    localparam int VW        = $clog2(NUM_VOICES),
    localparam int MIX_WIDTH = WAVE_WIDTH + VW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [VW-1:0]         cfg_voice,
    input  logic [1:0]            cfg_field,
    input  logic [TUNE_WIDTH-1:0] cfg_data,
    output logic [MIX_WIDTH-1:0]  mix_out,
    output logic                  mix_valid,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [VW:0]           NV_LIM   = (VW+1)'(NUM_VOICES);
    localparam logic [VW-1:0]         LAST_IDX = VW'(NUM_VOICES - 1);
    localparam logic [WAVE_WIDTH-1:0] PW_RST   = {1'b1, {(WAVE_WIDTH-1){1'b0}}};

    state_t state_q, state_d;

    logic [TUNE_WIDTH-1:0] phase_q [NUM_VOICES];
    logic [TUNE_WIDTH-1:0] tune_q  [NUM_VOICES];
    logic [1:0]            wsel_q  [NUM_VOICES];
    logic                  en_q    [NUM_VOICES];
    logic [WAVE_WIDTH-1:0] pw_q    [NUM_VOICES];

    logic [VW-1:0]         idx_q;
    logic [MIX_WIDTH-1:0]  acc_q;
    logic [MIX_WIDTH-1:0]  acc_nxt;
    logic [TUNE_WIDTH-1:0] cur_phase;
    logic [WAVE_WIDTH-1:0] p;
    logic [WAVE_WIDTH-1:0] tri_t;
    logic [WAVE_WIDTH-1:0] sample;
    logic                  last_voice;
    logic                  cfg_fire;
    logic                  voice_ok;

    assign cfg_ready  = (state_q == IDLE);
    assign busy       = (state_q == SCAN) || (state_q == DONE);
    assign cfg_fire   = cfg_valid && cfg_ready;
    assign voice_ok   = ({1'b0, cfg_voice} < NV_LIM);
    assign last_voice = (idx_q == LAST_IDX);

    assign cur_phase = phase_q[idx_q];
    assign p         = cur_phase[TUNE_WIDTH-1 -: WAVE_WIDTH];
    assign tri_t     = {p[WAVE_WIDTH-2:0], 1'b0};

    always_comb begin
        sample = '0;
        case (wsel_q[idx_q])
            2'd0:    sample = p;
            2'd1:    sample = (p < pw_q[idx_q]) ? '1 : '0;
            2'd2:    sample = p[WAVE_WIDTH-1] ? ~tri_t : tri_t;
            default: sample = '0;
        endcase
    end

    // Accumulator is sized so NUM_VOICES full-scale samples cannot overflow.
    assign acc_nxt = acc_q + (en_q[idx_q] ? MIX_WIDTH'(sample) : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_tick) state_d = SCAN;
            SCAN:    if (last_voice)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q     <= '0;
            acc_q     <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= '0;
                tune_q[v]  <= '0;
                wsel_q[v]  <= '0;
                en_q[v]    <= 1'b0;
                pw_q[v]    <= PW_RST;
            end
        end else begin
            mix_valid <= 1'b0;
            overrun   <= sample_tick && (state_q != IDLE);

            if (cfg_fire && voice_ok) begin
                case (cfg_field)
                    2'd0: tune_q[cfg_voice] <= cfg_data;
                    2'd1: begin
                        wsel_q[cfg_voice] <= cfg_data[1:0];
                        en_q[cfg_voice]   <= cfg_data[2];
                    end
                    2'd2: pw_q[cfg_voice] <= cfg_data[TUNE_WIDTH-1 -: WAVE_WIDTH];
                    default: phase_q[cfg_voice] <= cfg_data;
                endcase
            end

            case (state_q)
                IDLE: begin
                    if (sample_tick) begin
                        acc_q <= '0;
                        idx_q <= '0;
                    end
                end
                SCAN: begin
                    acc_q <= acc_nxt;
                    idx_q <= idx_q + VW'(1);
                    if (en_q[idx_q])
                        phase_q[idx_q] <= cur_phase + tune_q[idx_q];
                    // Result is published as the scan ends so it is visible during DONE.
                    if (last_voice) begin
                        mix_out   <= acc_nxt;
                        mix_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_voice_engine.sv
// Directed bench for dds_voice_engine (4 voices, 16-bit tune, 12-bit wave).
module tb_dds_voice_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_voice = '0;
    logic [1:0]  cfg_field = '0;
    logic [15:0] cfg_data = '0;
    logic [13:0] mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    int n_total = 0;
    int n_bad   = 0;
    int mvc, ovc, acc_c;
    logic [13:0] got;

    dds_voice_engine #(.NUM_VOICES(4), .TUNE_WIDTH(16), .WAVE_WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_voice(cfg_voice),
        .cfg_field(cfg_field), .cfg_data(cfg_data), .mix_out(mix_out),
        .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_wr(input logic [1:0] v, input logic [1:0] f, input logic [15:0] d);
        int budget;
        budget = 0;
        cfg_valid = 1'b1; cfg_voice = v; cfg_field = f; cfg_data = d;
        while (!cfg_ready && budget < 20) begin
            nxt();
            budget++;
        end
        if (!cfg_ready) chk("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
        nxt();
        cfg_valid = 1'b0;
    endtask

    task automatic start_tick();
        sample_tick = 1'b1;
        nxt();
        sample_tick = 1'b0;
    endtask

    task automatic wait_mix(input string tag, output logic [13:0] v);
        int n;
        n = 0;
        while (!mix_valid && n < 20) begin
            nxt();
            n++;
        end
        if (!mix_valid) begin
            chk({tag, "_timeout"}, 32'(mix_valid), 32'd1);
            v = 'x;
        end else begin
            v = mix_out;
        end
        nxt();
    endtask

    task automatic frame_chk(input string tag, input logic [13:0] exp);
        logic [13:0] v;
        start_tick();
        wait_mix(tag, v);
        chk(tag, 32'(v), 32'(exp));
    endtask

    // Cycle-exact trace of a frame with every voice disabled.
    task automatic idle_trace(input string tag);
        start_tick();
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(c <= 5));
            chk($sformatf("%s_valid_c%0d", tag, c), 32'(mix_valid), 32'(c == 5));
            if (c == 5) chk($sformatf("%s_mix", tag), 32'(mix_out), 32'h0);
            nxt();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) nxt();
        chk("rst_mix_out", 32'(mix_out), 32'h0);
        chk("rst_mix_valid", 32'(mix_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        nxt();
        chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);

        idle_trace("idle");

        cfg_wr(2'd0, 2'd0, 16'h1000);
        cfg_wr(2'd0, 2'd1, 16'h0004);
        for (int k = 0; k <= 16; k++)
            frame_chk($sformatf("saw%0d", k), 14'((k % 16) * 256));
        cfg_wr(2'd0, 2'd1, 16'h0000);

        cfg_wr(2'd1, 2'd2, 16'h8000);
        cfg_wr(2'd1, 2'd0, 16'h8000);
        cfg_wr(2'd1, 2'd1, 16'h0005);
        for (int k = 0; k < 4; k++)
            frame_chk($sformatf("square%0d", k), (k % 2 == 0) ? 14'h0FFF : 14'h0000);
        cfg_wr(2'd1, 2'd1, 16'h0000);

        cfg_wr(2'd2, 2'd3, 16'h7FF0);
        cfg_wr(2'd2, 2'd1, 16'h0006);
        frame_chk("tri_rise", 14'h0FFE);
        cfg_wr(2'd2, 2'd3, 16'h8000);
        frame_chk("tri_fall", 14'h0FFF);
        cfg_wr(2'd2, 2'd1, 16'h0000);

        for (int v = 0; v < 4; v++) begin
            cfg_wr(2'(v), 2'd0, 16'h0000);
            cfg_wr(2'(v), 2'd3, 16'hFFFF);
            cfg_wr(2'(v), 2'd1, 16'h0004);
        end
        for (int k = 0; k < 3; k++)
            frame_chk($sformatf("full%0d", k), 14'h3FFC);

        // Tick dropped mid-scan plus a write held off until IDLE.
        start_tick();
        mvc = 0; ovc = 0; acc_c = 0;
        for (int c = 1; c <= 12; c++) begin
            if (mix_valid) begin
                mvc++;
                chk("ovr_mix", 32'(mix_out), 32'h3FFC);
            end
            if (overrun) ovc++;
            if (c == 3) begin
                chk("ovr_pulse_c3", 32'(overrun), 32'h1);
                chk("ovr_ready_c3", 32'(cfg_ready), 32'h0);
            end
            if (cfg_valid && cfg_ready && acc_c == 0) acc_c = c;
            if (c == 1) begin
                cfg_valid = 1'b1; cfg_voice = 2'd0; cfg_field = 2'd3; cfg_data = 16'h0000;
            end
            sample_tick = (c == 2);
            if (acc_c != 0 && c > acc_c) cfg_valid = 1'b0;
            nxt();
        end
        chk("ovr_valid_count", 32'(mvc), 32'd1);
        chk("ovr_overrun_count", 32'(ovc), 32'd1);
        chk("ovr_accept_cycle", 32'(acc_c), 32'd6);
        frame_chk("post_write", 14'h2FFD);

        // Reset asserted in cycle 3 of a scan.
        cfg_wr(2'd0, 2'd0, 16'h1000);
        cfg_wr(2'd0, 2'd3, 16'h5000);
        start_tick();
        nxt();
        nxt();
        rst_n = 1'b0;
        mvc = 0;
        for (int i = 0; i < 10; i++) begin
            nxt();
            if (i == 0) rst_n = 1'b1;
            if (mix_valid) mvc++;
        end
        chk("abort_no_valid", 32'(mvc), 32'd0);
        chk("abort_mix_out", 32'(mix_out), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        idle_trace("post_rst");
        cfg_wr(2'd0, 2'd1, 16'h0004);
        frame_chk("rst_phase0", 14'h0000);
        frame_chk("rst_tune0", 14'h0000);
        cfg_wr(2'd1, 2'd1, 16'h0005);
        frame_chk("rst_v1_phase", 14'h0FFF);
        cfg_wr(2'd1, 2'd3, 16'h7FF0);
        frame_chk("rst_pw_below", 14'h0FFF);
        cfg_wr(2'd1, 2'd3, 16'h8000);
        frame_chk("rst_pw_at", 14'h0000);

        // Write coinciding with the tick is visible to that scan.
        cfg_valid = 1'b1; cfg_voice = 2'd0; cfg_field = 2'd3; cfg_data = 16'h1230;
        sample_tick = 1'b1;
        nxt();
        cfg_valid = 1'b0;
        sample_tick = 1'b0;
        wait_mix("tick_write", got);
        chk("tick_write", 32'(got), 32'h0123);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
